// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake and adder-side bus of the nibble-serial adder sequencer.
// slave is the sequencer's view; master is the producer/consumer/adder side.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;

  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_s;
  logic             add_cout;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Feeds a WIDTH-bit addition through an external 4-bit adder one nibble per
// cycle, LSB first, chaining the carry and presenting the registered result.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for an operand pair
// ADD    | driving nibble idx to the adder, capturing its sum and carry
// DONE   | out_valid=1, result held until out_ready
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                          clk,
  input logic                          rst,
  nibble_serial_adder_ctrl_if.slave    bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[4*idx_q +: 4] = bus.add_s;
        carry_d             = bus.add_cout;
        if (idx_q == IDX_LAST) begin
          cout_d  = bus.add_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Adder inputs are forced to zero outside ADD so the adder sees a quiet bus.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.add_a     = (state_q == S_ADD) ? a_q[4*idx_q +: 4] : 4'h0;
  assign bus.add_b     = (state_q == S_ADD) ? b_q[4*idx_q +: 4] : 4'h0;
  assign bus.add_cin   = (state_q == S_ADD) ? carry_q : 1'b0;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl: directed operations push the
// expected result; a monitor pops and compares on each output transfer.
module tb_nibble_serial_adder_ctrl;
  localparam int WIDTH = 16;

  logic clk;
  logic rst;

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // external 4-bit ripple adder
  assign {bus.add_cout, bus.add_s} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int wait_cycles;

  logic [WIDTH:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 32'(bus.out_sum), 32'hDEAD_BEEF);
      end else begin
        logic [WIDTH:0] e;
        e = sb_q.pop_front();
        chk("out_sum", 32'(bus.out_sum), 32'(e[WIDTH-1:0]));
        chk("out_cout", 32'(bus.out_cout), 32'(e[WIDTH]));
      end
    end
  end

  // Present operands, wait for acceptance, check the nibble stream and latency.
  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                    input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                    input logic [3:0] exp_cin_seq);
    logic got;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    got = 1'b0;
    wait_cycles = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      wait_cycles++;
      if (bus.in_ready) got = 1'b1;
    end
    if (!got) begin
      chk("in_ready_timeout", 32'(0), 32'(1));
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back({exp_cout, exp_sum});
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      @(negedge clk);
      chk("add_a", 32'(bus.add_a), 32'(a[4*i +: 4]));
      chk("add_b", 32'(bus.add_b), 32'(b[4*i +: 4]));
      chk("add_cin", 32'(bus.add_cin), 32'(exp_cin_seq[i]));
      chk("in_ready_busy", 32'(bus.in_ready), 32'(0));
    end
    @(negedge clk);
    chk("out_valid_latency", 32'(bus.out_valid), 32'(1));
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_sum", 32'(bus.out_sum), 32'h0000);
    chk("rst_out_cout", 32'(bus.out_cout), 32'(0));
    chk("rst_add_a", 32'(bus.add_a), 32'(0));
    chk("rst_add_b", 32'(bus.add_b), 32'(0));
    chk("rst_add_cin", 32'(bus.add_cin), 32'(0));

    @(posedge clk); #1;
    op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000);
    @(posedge clk); #1;
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110);
    @(posedge clk); #1;
    op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4'b1111);
    @(posedge clk); #1;
    op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 4'b0001);

    // Backpressure: hold the result while a new operand waits.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    op(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 4'b1110);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0007;
    bus.in_b     = 16'h0008;
    bus.in_cin   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'(1));
      chk("bp_out_sum", 32'(bus.out_sum), 32'h1000);
      chk("bp_out_cout", 32'(bus.out_cout), 32'(0));
      chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'(0));
    op(16'h0007, 16'h0008, 1'b0, 16'h000F, 1'b0, 4'b0000);
    chk("bp_pending_accept_wait", 32'(wait_cycles), 32'(1));

    // Reset during the third ADD cycle discards the operation.
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0F0F;
    bus.in_b     = 16'h0101;
    bus.in_cin   = 1'b0;
    begin
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        if (bus.in_ready) ok = 1'b1;
      end
      if (!ok) chk("rst_op_ready_timeout", 32'(0), 32'(1));
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("midrst_out_sum", 32'(bus.out_sum), 32'h0000);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midrst_add_a", 32'(bus.add_a), 32'(0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(bus.out_valid), 32'(0));
    end
    @(posedge clk); #1;
    op(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 4'b0000);

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
